// File: rtl/weight_loader.sv
// weight_loader: 4x4 single-precision weight matrix, filled either from a
// valid/ready word stream or internally as a Maxnet matrix (+1 diagonal, -eps elsewhere).
`default_nettype none

module weight_loader #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            start_fill,
  input  logic [XLEN-1:0] fill_eps,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_data,
  output logic            in_ready,
  output logic            busy,
  output logic            loaded,
  output logic [XLEN-1:0] W0,
  output logic [XLEN-1:0] W1,
  output logic [XLEN-1:0] W2,
  output logic [XLEN-1:0] W3,
  output logic [XLEN-1:0] W4,
  output logic [XLEN-1:0] W5,
  output logic [XLEN-1:0] W6,
  output logic [XLEN-1:0] W7,
  output logic [XLEN-1:0] W8,
  output logic [XLEN-1:0] W9,
  output logic [XLEN-1:0] W10,
  output logic [XLEN-1:0] W11,
  output logic [XLEN-1:0] W12,
  output logic [XLEN-1:0] W13,
  output logic [XLEN-1:0] W14,
  output logic [XLEN-1:0] W15
);

  localparam logic [XLEN-1:0] c_POS_ONE  = XLEN'(32'h3F80_0000);
  localparam logic [XLEN-1:0] c_NEG_0P2  = XLEN'(32'hBE4C_CCCD);
  localparam logic [XLEN-1:0] c_SIGN_BIT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_idx;
  logic [XLEN-1:0] r_eps;
  logic            r_loaded;
  logic [XLEN-1:0] r_w [16];

  logic            w_wr_en;
  logic [XLEN-1:0] w_wr_data;
  logic            w_done;
  logic            w_begin;
  logic            w_diag;

  assign w_diag = (r_idx[3:2] == r_idx[1:0]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_data   = in_data;
    w_done      = 1'b0;
    w_begin     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // start wins over start_fill when both arrive together
        if (start) begin
          w_state_nxt = S_LOAD;
          w_begin     = 1'b1;
        end else if (start_fill) begin
          w_state_nxt = S_FILL;
          w_begin     = 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          w_wr_en = 1'b1;
          if (r_idx == 4'd15) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_FILL: begin
        w_wr_en   = 1'b1;
        w_wr_data = w_diag ? c_POS_ONE : (r_eps | c_SIGN_BIT);
        if (r_idx == 4'd15) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= 4'd0;
      r_loaded <= 1'b1;
      r_eps    <= '0;
      for (int i = 0; i < 16; i++)
        r_w[i] <= ((i % 5) == 0) ? c_POS_ONE : c_NEG_0P2;
    end else begin
      if (w_begin) begin
        r_idx    <= 4'd0;
        r_loaded <= 1'b0;
        if (!start) r_eps <= fill_eps;
      end
      // idx wraps 15 -> 0 naturally on the final write
      if (w_wr_en) begin
        r_w[r_idx] <= w_wr_data;
        r_idx      <= r_idx + 4'd1;
      end
      if (w_done) r_loaded <= 1'b1;
    end
  end

  assign in_ready = (r_state == S_LOAD);
  assign busy     = (r_state != S_IDLE);
  assign loaded   = r_loaded;

  assign W0  = r_w[0];
  assign W1  = r_w[1];
  assign W2  = r_w[2];
  assign W3  = r_w[3];
  assign W4  = r_w[4];
  assign W5  = r_w[5];
  assign W6  = r_w[6];
  assign W7  = r_w[7];
  assign W8  = r_w[8];
  assign W9  = r_w[9];
  assign W10 = r_w[10];
  assign W11 = r_w[11];
  assign W12 = r_w[12];
  assign W13 = r_w[13];
  assign W14 = r_w[14];
  assign W15 = r_w[15];

endmodule

`default_nettype wire

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed self-checking bench for weight_loader.
`default_nettype none

module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_fill;
  logic [31:0] fill_eps;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        loaded;
  logic [31:0] w [16];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  weight_loader #(.XLEN(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_fill (start_fill),
    .fill_eps   (fill_eps),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .loaded     (loaded),
    .W0  (w[0]),  .W1  (w[1]),  .W2  (w[2]),  .W3  (w[3]),
    .W4  (w[4]),  .W5  (w[5]),  .W6  (w[6]),  .W7  (w[7]),
    .W8  (w[8]),  .W9  (w[9]),  .W10 (w[10]), .W11 (w[11]),
    .W12 (w[12]), .W13 (w[13]), .W14 (w[14]), .W15 (w[15])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_default(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_w%0d", tag, i), w[i],
            ((i % 5) == 0) ? 32'h3F80_0000 : 32'hBE4C_CCCD);
    check({tag, "_loaded"}, loaded, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  int cnt;
  int hs;

  initial begin
    // reset, with start also asserted to show reset dominates
    rst = 1; start = 1; start_fill = 0; fill_eps = 0; in_valid = 0; in_data = 0;
    tick();
    rst = 0; start = 0;
    check_default("rst");

    // back-to-back load of 0..15
    start = 1;
    tick();
    start = 0;
    in_valid = 1;
    check("load_ready", in_ready, 1);
    for (int k = 0; k < 16; k++) begin
      in_data = k;
      if (k == 15) begin
        check("load_loaded_c16", loaded, 0);
        check("load_busy_c16", busy, 1);
      end
      tick();
    end
    in_valid = 0;
    check("load_loaded_c17", loaded, 1);
    check("load_ready_after", in_ready, 0);
    check("load_busy_after", busy, 0);
    for (int i = 0; i < 16; i++) check($sformatf("load_w%0d", i), w[i], i);

    // Maxnet fill with eps = 0.1; eps changed afterwards to prove it was sampled
    fill_eps = 32'h3DCC_CCCD;
    start_fill = 1;
    tick();
    start_fill = 0;
    fill_eps = 32'h0000_0000;
    check("fill_loaded_clr", loaded, 0);
    check("fill_ready", in_ready, 0);
    cnt = 0;
    while (busy && cnt < 40) begin
      tick();
      cnt++;
    end
    check("fill_cycles", cnt, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("fill_w%0d", i), w[i],
            ((i % 5) == 0) ? 32'h3F80_0000 : 32'hBDCC_CCCD);
    check("fill_loaded", loaded, 1);

    // alternating in_valid: 32 cycles including the start cycle
    start = 1;
    tick();
    start = 0;
    cnt = 1;
    hs = 0;
    while (!loaded && cnt < 80) begin
      in_valid = ((cnt - 1) % 2) == 0;
      in_data  = 32'h100 + hs;
      tick();
      if (in_valid) hs++;
      cnt++;
    end
    in_valid = 0;
    check("tog_cycles", cnt, 32);
    check("tog_words", hs, 16);
    for (int i = 0; i < 16; i++) check($sformatf("tog_w%0d", i), w[i], 32'h100 + i);

    // reset after 7 accepted words, handshake pending in the reset cycle
    start = 1;
    tick();
    start = 0;
    in_valid = 1;
    for (int k = 0; k < 7; k++) begin
      in_data = 32'h300 + k;
      tick();
    end
    check("abort_w6_written", w[6], 32'h306);
    check("abort_w7_old", w[7], 32'h107);
    check("abort_loaded_mid", loaded, 0);
    in_data = 32'hDEAD_BEEF;
    rst = 1;
    tick();
    rst = 0;
    in_valid = 0;
    check_default("abort");

    // start and start_fill together -> LOAD; start_fill mid-load ignored
    fill_eps = 32'h3DCC_CCCD;
    start = 1;
    start_fill = 1;
    tick();
    start = 0;
    start_fill = 0;
    check("prio_ready", in_ready, 1);
    in_valid = 1;
    for (int k = 0; k < 16; k++) begin
      in_data = 32'h200 + k;
      start_fill = (k == 5);
      start = (k == 9);
      tick();
    end
    start_fill = 0;
    start = 0;
    in_valid = 0;
    check("prio_loaded", loaded, 1);
    check("prio_busy", busy, 0);
    for (int i = 0; i < 16; i++) check($sformatf("prio_w%0d", i), w[i], 32'h200 + i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
